// File: rtl/alu_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_issuer
// Purpose  : Queues upstream ALU commands in a small FIFO and issues them one
//            at a time to a handshake-style ALU. Exactly one operation is in
//            flight. Each result is held as a response until it is accepted.
// Revision : 1.0 - initial release
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready  upstream command handshake
//   i_cmd_inst/a/b           upstream opcode and operands
//   o_alu_in_valid           one-cycle issue strobe to the ALU
//   i_alu_busy               ALU busy; blocks issue while high
//   o_alu_inst/data_a/b      issued opcode/operands (held between issues)
//   i_alu_out_valid/data     ALU result strobe and value
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_inst/data/err      response opcode, result, watchdog flag
//   o_fifo_cnt               command FIFO occupancy
//
// Build option
//   ALU_ISSUER_TIMEOUT_EN    if defined, a watchdog ends WAIT_RES after
//                            TIMEOUT cycles with an error response
// ============================================================================
module alu_issuer #(
   parameter int INST_W     = 4,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [INST_W-1:0]             i_cmd_inst,
   input  logic [DATA_W-1:0]             i_cmd_a,
   input  logic [DATA_W-1:0]             i_cmd_b,
   output logic                          o_alu_in_valid,
   input  logic                          i_alu_busy,
   output logic [INST_W-1:0]             o_alu_inst,
   output logic [DATA_W-1:0]             o_alu_data_a,
   output logic [DATA_W-1:0]             o_alu_data_b,
   input  logic                          i_alu_out_valid,
   input  logic [DATA_W-1:0]             i_alu_data,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [INST_W-1:0]             o_rsp_inst,
   output logic [DATA_W-1:0]             o_rsp_data,
   output logic                          o_rsp_err,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;
   localparam logic [1:0] c_ST_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;

   logic [INST_W-1:0] r_mem_inst [FIFO_DEPTH];
   logic [DATA_W-1:0] r_mem_a    [FIFO_DEPTH];
   logic [DATA_W-1:0] r_mem_b    [FIFO_DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_cnt;

   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;
   logic              w_res_ok;
   logic              w_timeout;
   logic              w_start;

   logic [INST_W-1:0] r_alu_inst;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [INST_W-1:0] r_rsp_inst;
   logic [DATA_W-1:0] r_rsp_data;

   // ---------------- command FIFO ----------------
   assign w_full      = (r_cnt == c_CW'(FIFO_DEPTH));
   assign w_empty     = (r_cnt == '0);
   assign o_cmd_ready = ~w_full;
   assign o_fifo_cnt  = r_cnt;
   assign w_push      = i_cmd_valid & ~w_full;
   // ISSUE is only entered with a non-empty FIFO, so this pop never underflows
   assign w_pop       = (r_state == c_ST_ISSUE);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_inst[r_wr_ptr] <= i_cmd_inst;
         r_mem_a[r_wr_ptr]    <= i_cmd_a;
         r_mem_b[r_wr_ptr]    <= i_cmd_b;
      end
   end

   // Power-of-two depth: pointers wrap by natural overflow
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // ---------------- watchdog ----------------
   assign w_res_ok = (r_state == c_ST_WAIT) & i_alu_out_valid;

`ifdef ALU_ISSUER_TIMEOUT_EN
   localparam int                 c_WDW     = $clog2(TIMEOUT + 1);
   localparam logic [c_WDW-1:0]   c_WD_LAST = c_WDW'(TIMEOUT - 1);

   logic [c_WDW-1:0] r_wd_cnt;
   logic             r_rsp_err;

   // Cleared while issuing so it starts from zero on WAIT_RES entry
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                     r_wd_cnt <= '0;
      else if (r_state == c_ST_ISSUE)   r_wd_cnt <= '0;
      else if ((r_state == c_ST_WAIT) && !i_alu_out_valid)
                                        r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   // Fires on the WAIT_RES cycle in which the count reaches TIMEOUT
   assign w_timeout = (r_state == c_ST_WAIT) & ~i_alu_out_valid &
                      (r_wd_cnt == c_WD_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)       r_rsp_err <= 1'b0;
      else if (w_res_ok)  r_rsp_err <= 1'b0;
      else if (w_timeout) r_rsp_err <= 1'b1;
   end

   assign o_rsp_err = r_rsp_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |32'(TIMEOUT);
   assign w_timeout        = 1'b0;
   assign o_rsp_err        = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= c_ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (!w_empty && !i_alu_busy)   w_state_nxt = c_ST_ISSUE;
         c_ST_ISSUE:                                w_state_nxt = c_ST_WAIT;
         c_ST_WAIT:  if (w_res_ok || w_timeout)     w_state_nxt = c_ST_RESP;
         c_ST_RESP:  if (i_rsp_ready)               w_state_nxt = c_ST_IDLE;
         default:                                   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_alu_in_valid = (r_state == c_ST_ISSUE);
      o_rsp_valid    = (r_state == c_ST_RESP);
   end

   // ---------------- datapath registers ----------------
   // Operands are latched from the FIFO head on the way into ISSUE, so they
   // match the head during ISSUE and hold afterwards.
   assign w_start = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_ISSUE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_alu_inst <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_rsp_inst <= '0;
         r_rsp_data <= '0;
      end else begin
         if (w_start) begin
            r_alu_inst <= r_mem_inst[r_rd_ptr];
            r_alu_a    <= r_mem_a[r_rd_ptr];
            r_alu_b    <= r_mem_b[r_rd_ptr];
         end
         if (w_res_ok) begin
            r_rsp_inst <= r_alu_inst;
            r_rsp_data <= i_alu_data;
         end else if (w_timeout) begin
            r_rsp_inst <= r_alu_inst;
            r_rsp_data <= '0;
         end
      end
   end

   assign o_alu_inst   = r_alu_inst;
   assign o_alu_data_a = r_alu_a;
   assign o_alu_data_b = r_alu_b;
   assign o_rsp_inst   = r_rsp_inst;
   assign o_rsp_data   = r_rsp_data;

endmodule
`default_nettype wire
